// File: rtl/s_term_edge_capture_if.sv
// Drain port of the south-edge capture stage: FIFO head data with a
// valid/ready handshake towards the readback/debug chain.
interface s_term_edge_capture_if #(
  parameter int DATA_W = 36
) ();
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/s_term_edge_capture.sv
// South-edge debug capture: samples the S1END/S2END/S4END routing wires,
// waits for a programmable trigger, then records timestamped change events
// into a first-word-fall-through FIFO drained over a valid/ready port.
module s_term_edge_capture #(
  parameter int DEPTH       = 8,
  parameter int CAPTURE_LEN = 16,
  parameter int TS_W        = 8
) (
  input  logic                   UserCLK,
  input  logic                   RST,
  input  logic [3:0]             S1END,
  input  logic [7:0]             S2END,
  input  logic [15:0]            S4END,
  input  logic                   arm,
  input  logic                   trig_mode,
  input  logic [27:0]            trig_mask,
  input  logic [27:0]            trig_value,
  s_term_edge_capture_if.master  drain,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   done
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = 28;
  localparam int DW = TS_W + SW;
  localparam int CW = $clog2(CAPTURE_LEN + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  logic [SW-1:0]   s_q;
  logic [SW-1:0]   prev;
  logic            prev_vld;
  logic [TS_W-1:0] ts;
  logic [CW-1:0]   cnt;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            valid;

  logic            change;
  logic            match;
  logic            trig;
  logic            push;
  logic            pop;
  logic            full;
  logic            push_ok;
  logic [AW:0]     count_next;

  assign drain.out_data  = mem[rd_ptr];
  assign drain.out_valid = valid;

  // Change/trigger detection and FIFO push/pop qualification.
  always_comb begin
    change = 1'b0;
    match  = 1'b0;
    trig   = 1'b0;
    push   = 1'b0;
    // prev_vld masks the first compare after reset or after leaving IDLE
    if (prev_vld) begin
      change = (s_q != prev);
    end else begin
      change = 1'b0;
    end
    match = (((s_q ^ trig_value) & trig_mask) == 28'h0000000);
    if (trig_mode) begin
      trig = match;
    end else begin
      trig = change;
    end
    // dropping arm suppresses any push in the cycle it is seen low
    if (arm) begin
      case (state)
        ARMED:   push = trig;
        CAPTURE: push = change;
        default: push = 1'b0;
      endcase
    end else begin
      push = 1'b0;
    end
    full       = (fifo_count == (AW+1)'(DEPTH));
    pop        = valid & drain.out_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    push_ok    = push & (~full | pop);
    count_next = fifo_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
  end

  // Edge-wire sampling, timestamp, sample counter and capture FSM.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      state    <= IDLE;
      s_q      <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      ts       <= '0;
      cnt      <= '0;
      done     <= 1'b0;
    end else begin
      s_q  <= {S4END, S2END, S1END};
      prev <= s_q;
      if (!arm) begin
        state    <= IDLE;
        prev_vld <= 1'b0;
        ts       <= '0;
        cnt      <= '0;
        done     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state    <= ARMED;
            prev_vld <= 1'b0;
            ts       <= '0;
            cnt      <= '0;
            done     <= 1'b0;
          end
          ARMED: begin
            prev_vld <= 1'b1;
            ts       <= ts + TS_W'(1);
            if (trig) begin
              cnt <= CW'(1);
              if (CAPTURE_LEN == 1) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= CAPTURE;
              end
            end
          end
          CAPTURE: begin
            prev_vld <= 1'b1;
            ts       <= ts + TS_W'(1);
            if (change) begin
              cnt <= cnt + CW'(1);
              if ((cnt + CW'(1)) == CW'(CAPTURE_LEN)) begin
                state <= DONE;
                done  <= 1'b1;
              end
            end
          end
          DONE: begin
            done <= 1'b1;
          end
          default: begin
            state <= IDLE;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Event FIFO storage, pointers, occupancy and sticky overflow flag.
  always_ff @(posedge UserCLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      valid      <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= {ts, s_q};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      fifo_count <= count_next;
      valid      <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_s_term_edge_capture.sv
// Directed bench for s_term_edge_capture with hand-computed expectations.
module tb_s_term_edge_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  s1;
  logic [7:0]  s2;
  logic [15:0] s4;
  logic        arm;
  logic        trig_mode;
  logic [27:0] trig_mask;
  logic [27:0] trig_value;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;

  s_term_edge_capture_if #(.DATA_W(36)) drain_if ();

  s_term_edge_capture #(
    .DEPTH(8), .CAPTURE_LEN(16), .TS_W(8)
  ) dut (
    .UserCLK   (clk),
    .RST       (rst),
    .S1END     (s1),
    .S2END     (s2),
    .S4END     (s4),
    .arm       (arm),
    .trig_mode (trig_mode),
    .trig_mask (trig_mask),
    .trig_value(trig_value),
    .drain     (drain_if),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ent(input logic [7:0] t, input logic [27:0] smp);
    return {28'd0, t, smp};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then arm=1 with RST low; the following edge enters ARMED.
  task automatic do_reset(input logic mode);
    rst = 1'b1; arm = 1'b0; trig_mode = mode;
    s1 = 4'h0; s2 = 8'h00; s4 = 16'h0000;
    drain_if.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; arm = 1'b1;
  endtask

  initial begin
    trig_mask  = 28'h0000000;
    trig_value = 28'h0000000;
    do_reset(1'b0);

    // reset state
    check("rst_valid", 64'(drain_if.out_valid), 64'd0);
    check("rst_count", 64'(fifo_count), 64'd0);
    check("rst_ovf",   64'(overflow), 64'd0);
    check("rst_done",  64'(done), 64'd0);
    check("rst_data",  64'(drain_if.out_data), 64'd0);

    // 1: any-change trigger, toggle S1END[0] five cycles after arming
    for (int i = 0; i < 5; i++) tick();
    s1 = 4'h1;
    tick();
    check("t1_valid_early", 64'(drain_if.out_valid), 64'd0);
    tick();
    check("t1_valid", 64'(drain_if.out_valid), 64'd1);
    check("t1_data",  64'(drain_if.out_data), ent(8'd5, 28'h0000001));
    check("t1_count", 64'(fifo_count), 64'd1);

    // 2/3: masked-match trigger, 15 further changes with out_ready low
    trig_mask  = 28'hFFF0000;
    trig_value = 28'h0A50000;
    do_reset(1'b1);
    tick();
    s4 = 16'h0A50;
    tick(); tick();
    check("t2_trig_valid", 64'(drain_if.out_valid), 64'd1);
    check("t2_trig_data",  64'(drain_if.out_data), ent(8'd1, 28'h0A50000));
    for (int i = 1; i <= 15; i++) begin
      s1 = 4'(i);
      tick();
    end
    check("t2_done_early", 64'(done), 64'd0);
    tick();
    check("t2_done",  64'(done), 64'd1);
    check("t3_count", 64'(fifo_count), 64'd8);
    check("t3_ovf",   64'(overflow), 64'd1);
    drain_if.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 0) check("t3_drain0", 64'(drain_if.out_data), ent(8'd1, 28'h0A50000));
      else        check("t3_drain",  64'(drain_if.out_data), ent(8'(j + 2), 28'h0A50000 | 28'(j)));
      tick();
    end
    drain_if.out_ready = 1'b0;
    check("t3_empty_valid", 64'(drain_if.out_valid), 64'd0);
    check("t3_empty_count", 64'(fifo_count), 64'd0);

    // 4: fill the FIFO, then push and pop in the same cycle
    trig_mask  = 28'h0000000;
    trig_value = 28'h0000000;
    do_reset(1'b0);
    tick(); tick(); tick();
    for (int i = 1; i <= 8; i++) begin
      s1 = 4'(i);
      tick();
    end
    tick();
    check("t4_full_count", 64'(fifo_count), 64'd8);
    check("t4_full_ovf",   64'(overflow), 64'd0);
    check("t4_full_head",  64'(drain_if.out_data), ent(8'd3, 28'd1));
    s1 = 4'd9;
    tick();
    drain_if.out_ready = 1'b1;
    tick();
    drain_if.out_ready = 1'b0;
    check("t4_pp_count", 64'(fifo_count), 64'd8);
    check("t4_pp_ovf",   64'(overflow), 64'd0);
    check("t4_pp_head",  64'(drain_if.out_data), ent(8'd4, 28'd2));
    s1 = 4'd10;
    tick(); tick();
    check("t4_drop_ovf",   64'(overflow), 64'd1);
    check("t4_drop_count", 64'(fifo_count), 64'd8);
    check("t4_drop_head",  64'(drain_if.out_data), ent(8'd4, 28'd2));

    // 5a: pop two, then drop arm in the cycle a change is pending
    drain_if.out_ready = 1'b1;
    tick(); tick();
    drain_if.out_ready = 1'b0;
    check("t5_pop_count", 64'(fifo_count), 64'd6);
    s1 = 4'd11;
    tick();
    arm = 1'b0;
    tick(); tick(); tick();
    check("t5_disarm_count", 64'(fifo_count), 64'd6);
    check("t5_disarm_head",  64'(drain_if.out_data), ent(8'd6, 28'd4));
    check("t5_disarm_ovf",   64'(overflow), 64'd1);
    check("t5_disarm_done",  64'(done), 64'd0);
    // re-arm and capture one more event into the retained FIFO
    arm = 1'b1;
    tick(); tick();
    s1 = 4'd12;
    tick(); tick(); tick();
    check("t5_rearm_count", 64'(fifo_count), 64'd7);

    // 5b: RST mid-capture empties everything; stale s_q change is masked
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_count", 64'(fifo_count), 64'd0);
    check("t5_rst_valid", 64'(drain_if.out_valid), 64'd0);
    check("t5_rst_data",  64'(drain_if.out_data), 64'd0);
    check("t5_rst_ovf",   64'(overflow), 64'd0);
    tick(); tick(); tick();
    s1 = 4'd13;
    tick(); tick();
    check("t5_ts_count", 64'(fifo_count), 64'd1);
    check("t5_ts_data",  64'(drain_if.out_data), ent(8'd3, 28'd13));

    // 6: long ARMED wait, trigger at ts=255 and next change at wrapped ts=0
    do_reset(1'b0);
    for (int i = 0; i < 255; i++) tick();
    s1 = 4'd1;
    tick();
    s1 = 4'd2;
    tick(); tick();
    check("t6_count", 64'(fifo_count), 64'd2);
    check("t6_head",  64'(drain_if.out_data), ent(8'hFF, 28'd1));
    drain_if.out_ready = 1'b1;
    tick();
    drain_if.out_ready = 1'b0;
    check("t6_wrap",  64'(drain_if.out_data), ent(8'h00, 28'd2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
